// File: rtl/muldiv_unit_if.sv
// Bundle connecting the EX-stage decoder controls and operands to the multiply/divide unit.
// The master side is the pipeline (or a bench); the slave side is the unit itself.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             multdiv;
    logic [5:0]       funct;
    logic [1:0]       hilo;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             stall;

    modport master (
        output multdiv, funct, hilo, srca, srcb,
        input  result, busy, stall
    );

    modport slave (
        input  multdiv, funct, hilo, srca, srcb,
        output result, busy, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring) with HI/LO registers.
// One iteration per cycle on operand magnitudes; sign correction in a final FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    state_t          state_d;
    logic [CW-1:0]   counter;
    logic [2*W:0]    acc;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic            sign_a;
    logic            sign_b;
    logic            op_div;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;

    logic [2*W:0]    acc_step;
    logic [W:0]      sum;
    logic [W:0]      rem_s;
    logic [W:0]      diff;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot;
    logic [W-1:0]    rem;
    logic [W-1:0]    hi_fix;
    logic [W-1:0]    lo_fix;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic
    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.multdiv) state_d = RUN;
            RUN:     if (counter == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: a read or second start while busy must be held in EX.
    always_comb begin
        bus.busy  = (state != IDLE);
        bus.stall = bus.busy & (bus.multdiv | (bus.hilo == 2'b10) | (bus.hilo == 2'b01));
        case (bus.hilo)
            2'b10:   bus.result = hi;
            2'b01:   bus.result = lo;
            default: bus.result = '0;
        endcase
    end

    // One iteration step; acc[2W] stays zero between steps and only absorbs the add carry.
    always_comb begin
        sum   = {1'b0, acc[2*W-1:W]} + {1'b0, opa};
        rem_s = {acc[2*W-1:W], acc[W-1]};
        diff  = rem_s - {1'b0, opb};
        if (!op_div)
            acc_step = acc[0] ? {1'b0, sum, acc[W-1:1]} : {1'b0, acc[2*W:1]};
        else if (diff[W])
            acc_step = {rem_s, acc[W-2:0], 1'b0};
        else
            acc_step = {diff, acc[W-2:0], 1'b1};
    end

    // Sign correction; a zero divisor bypasses it and reports the original dividend in HI.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc[2*W-1:0] : acc[2*W-1:0];
        quot     = acc[W-1:0];
        rem      = acc[2*W-1:W];
        if (!op_div) begin
            hi_fix = prod_fix[2*W-1:W];
            lo_fix = prod_fix[W-1:0];
        end else if (opb == '0) begin
            hi_fix = sign_a ? -opa : opa;
            lo_fix = '1;
        end else begin
            hi_fix = sign_a ? -rem : rem;
            lo_fix = (sign_a ^ sign_b) ? -quot : quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_div  <= 1'b0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: if (bus.multdiv) begin
                    opa     <= mag(bus.srca);
                    opb     <= mag(bus.srcb);
                    sign_a  <= bus.srca[W-1];
                    sign_b  <= bus.srcb[W-1];
                    op_div  <= bus.funct[1];
                    acc     <= {{(W+1){1'b0}}, bus.funct[1] ? mag(bus.srca) : mag(bus.srcb)};
                    counter <= '0;
                end
                RUN: begin
                    acc     <= acc_step;
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    hi <= hi_fix;
                    lo <= lo_fix;
                end
                default: ;
            endcase
        end
    end
endmodule
